// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// MAX_N bounds the requester count the helpers can handle; vectors are
// zero-extended to MAX_N bits before being passed in.
package ring_arb_pkg;

  localparam int MAX_N = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] mask;
    mask = {MAX_N{1'b1}} >> (MAX_N - n);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  // Binary index of a one-hot vector (0 for an all-zero vector).
  function automatic int onehot2bin(input logic [MAX_N-1:0] v);
    int b;
    b = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (((v >> i) & MAX_N'(1)) != '0) b = b | i;
    end
    return b;
  endfunction

endpackage

// File: rtl/ring_token.sv
// One-hot ring token register. On load it moves to the position just after
// the winner, so the last grantee becomes lowest priority.
module ring_token
  import ring_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [N-1:0] winner_oh,
  output logic [N-1:0] token
);

  logic [N-1:0] token_q;
  logic [N-1:0] token_d;

  // Next token: rotated winner when a grant is issued, otherwise hold.
  always_comb begin
    token_d = token_q;
    if (load) token_d = N'(rotl1(MAX_N'(winner_oh), N));
  end

  // Token register, resets to requester 0 having top priority.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) token_q <= N'(1);
    else      token_q <= token_d;
  end

  assign token = token_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token.
// Optional feature macro ARB_TIMEOUT_EN: adds a hold counter that forces a
// release after MAX_HOLD BUSY cycles and pulses the timeout output.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N-1:0]                   req,
  input  logic                           done,
  output logic [N-1:0]                   gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
  output logic                           busy,
  output logic [N-1:0]                   token
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                           timeout
`endif
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("ring_rr_arbiter: N out of range");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("ring_rr_arbiter: MAX_HOLD must be >= 1");
  end

  state_t         state_q;
  logic [N-1:0]   gnt_q;
  logic [IDW-1:0] gnt_id_q;
  logic           busy_q;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [N-1:0]   win_oh;
  logic           rel_normal;
  logic           tok_load;
  int             pos;
  int             idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_cnt_q;
  logic          timeout_q;
`endif

  // Circular priority search: first requester at or above the token position.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    idx       = 0;
    pos       = onehot2bin(MAX_N'(token));
    for (int off = 0; off < N; off++) begin
      idx = (pos + off) % N;
      if (!win_found && (((req >> idx) & N'(1)) != '0)) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
        win_oh    = N'(1) << idx;
      end
    end
  end

  // The grantee releases by pulsing done or by dropping its own request.
  assign rel_normal = done || ((gnt_q & req) == '0);
  assign tok_load   = (state_q == IDLE) && win_found;

  ring_token #(.N(N)) u_token (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tok_load),
    .winner_oh(win_oh),
    .token    (token)
  );

  // Grant FSM with registered grant, index, busy and optional hold counter.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
          if (win_found) begin
            state_q  <= BUSY;
            gnt_q    <= win_oh;
            gnt_id_q <= win_idx;
            busy_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        BUSY: begin
          if (rel_normal) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
            // Forced release; a normal release in the same cycle wins above.
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter (N=4, MAX_HOLD=8).
// Build with ARB_TIMEOUT_EN defined to exercise the timeout feature.
module tb_ring_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic [N-1:0] token;
  logic         to_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference: integer token position and grantee index.
  bit m_busy;
  int m_gid;
  int m_tok;
  int m_cyc;
  bit m_to;

`ifdef ARB_TIMEOUT_EN
  logic timeout;
  assign to_o = timeout;
`else
  assign to_o = 1'b0;
`endif

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .token  (token)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy = 1'b0;
    m_gid  = 0;
    m_tok  = 0;
    m_cyc  = 0;
    m_to   = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic d);
    bit found;
    int c;
    if (!m_busy) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_tok + k) % N;
        if (!found && (((r >> c) & N'(1)) != '0)) begin
          found = 1'b1;
          m_gid = c;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_tok  = (m_gid + 1) % N;
        m_cyc  = 1;
      end
    end else begin
      if (d || (((r >> m_gid) & N'(1)) == '0)) begin
        m_busy = 1'b0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_cyc >= MH) begin
          m_busy = 1'b0;
          m_to   = 1'b1;
        end else begin
          m_cyc = m_cyc + 1;
        end
`endif
      end
    end
  endfunction

  function automatic logic [N-1:0] m_gnt();
    return m_busy ? (N'(1) << m_gid) : N'(0);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rstn) model_reset();
    else      model_step(req, done);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    req  = '0;
    done = 1'b0;
    repeat (4) tick();
    checks++;
    if ({gnt, gnt_id, busy, token} !== {4'b0000, 2'd0, 1'b0, 4'b0001}) begin
      failures++;
      $display("FAIL reset_state got gnt=%b id=%0d busy=%b tok=%b exp 0000/0/0/0001", gnt, gnt_id, busy, token);
    end
    rstn = 1'b0;
    done = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    checks++;
    if ({gnt, gnt_id, busy, token, to_o} !== {4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL idle_hold got gnt=%b id=%0d busy=%b tok=%b exp 0000/0/0/0001", gnt, gnt_id, busy, token);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] exp_t [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt !== exp_g[i] || token !== exp_t[i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL rot_grant%0d got gnt=%b tok=%b busy=%b exp gnt=%b tok=%b busy=1", i, gnt, token, busy, exp_g[i], exp_t[i]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || token !== exp_t[i]) begin
        failures++;
        $display("FAIL rot_gap%0d got gnt=%b busy=%b tok=%b exp gnt=0000 busy=0 tok=%b", i, gnt, busy, token, exp_t[i]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || token !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_first got gnt=%b id=%0d tok=%b exp 0100/2/1000", gnt, gnt_id, token);
    end
    req = 4'b0001;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || token !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_second got gnt=%b id=%0d tok=%b exp 0001/0/0010", gnt, gnt_id, token);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_hold();
    logic [N-1:0] eg;
    logic         et;
    do_reset();
    req  = 4'b0010;
    done = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      eg = ((t % (MH + 1)) == MH) ? 4'b0000 : 4'b0010;
      et = ((t % (MH + 1)) == MH);
`else
      eg = 4'b0010;
      et = 1'b0;
`endif
      checks++;
      if (gnt !== eg || to_o !== et) begin
        failures++;
        $display("FAIL hold_t%0d got gnt=%b timeout=%b exp gnt=%b timeout=%b", t, gnt, to_o, eg, et);
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0100 || token !== 4'b1000) begin
      failures++;
      $display("FAIL rel_others got gnt=%b tok=%b exp gnt=0100 tok=1000", gnt, token);
    end
    req = 4'b1011;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rel_reqdrop got gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy);
    end
    req = 4'b0100;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL rel_regrant got gnt=%b exp 0100", gnt);
    end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || to_o !== 1'b0) begin
      failures++;
      $display("FAIL rel_both got gnt=%b busy=%b timeout=%b exp 0000/0/0", gnt, busy, to_o);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || to_o !== 1'b0 || token !== 4'b1000) begin
      failures++;
      $display("FAIL rel_single got gnt=%b busy=%b timeout=%b tok=%b exp 0000/0/0/1000", gnt, busy, to_o, token);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL areset_pre got gnt=%b exp 0100", gnt);
    end
    #3;
    rstn = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({gnt, gnt_id, busy, token, to_o} !== {4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL areset_now got gnt=%b id=%0d busy=%b tok=%b exp 0000/0/0/0001", gnt, gnt_id, busy, token);
    end
    req = '0;
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] obs;
    logic [11:0] exp;
    do_reset();
    req  = '0;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      done = ($urandom_range(7) == 0);
      tick();
      obs = {gnt, gnt_id, busy, token, to_o};
      exp = {m_gnt(), (m_busy ? 2'(m_gid) : 2'd0), m_busy, N'(1) << m_tok, m_to};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random_c%0d got gnt/id/busy/tok/to=%b exp %b", i, obs, exp);
      end
    end
    req  = '0;
    done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rstn = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    test_reset();
    test_rotation();
    test_wrap();
    test_hold();
    test_release();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
